// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: host start pulse, response/bit timing in 1 us ticks,
// checksum verification and output byte holding.
//
// state      | meaning
// IDLE       | line released, waiting for start
// START_LOW  | host holds line low for T_START_LOW ticks
// WAIT_RESP  | line released, waiting for sensor to pull low
// RESP_LOW   | sensor 80 us low response
// RESP_HIGH  | sensor 80 us high response
// BIT_LOW    | 50 us low preamble of a data bit
// BIT_HIGH   | high phase, its length encodes the bit
// CHECK      | checksum compare, publish or flag error
module dht11_reader #(
  parameter int T_START_LOW  = 18000,
  parameter int T_TIMEOUT    = 200,
  parameter int T_BIT_THRESH = 48,
  parameter int CNT_W        = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_src,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] tmp_int,
  output logic [7:0] tmp_dec
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_LOW = 3'd1;
  localparam logic [2:0] WAIT_RESP = 3'd2;
  localparam logic [2:0] RESP_LOW  = 3'd3;
  localparam logic [2:0] RESP_HIGH = 3'd4;
  localparam logic [2:0] BIT_LOW   = 3'd5;
  localparam logic [2:0] BIT_HIGH  = 3'd6;
  localparam logic [2:0] CHECK     = 3'd7;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(T_START_LOW - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(T_TIMEOUT);
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(T_BIT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       bit_cnt;
  logic [39:0]      shift;
  logic             tick_src_q, tick;
  logic             dht_s1, dht_s2, dht_q;
  logic             rise, fall, timeout;
  logic             fail_now;
  logic [1:0]       fail_code;
  logic [7:0]       sum;

  assign tick    = tick_src & ~tick_src_q;
  assign rise    = dht_s2 & ~dht_q;
  assign fall    = ~dht_s2 & dht_q;
  assign timeout = (cnt >= TIMEOUT_C);
  assign sum     = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];

  // Edges are tested before the timeout so a late edge still advances.
  always_comb begin
    state_nxt = state;
    fail_now  = 1'b0;
    fail_code = 2'b00;
    case (state)
      IDLE:      if (start) state_nxt = START_LOW;
      START_LOW: if (tick && cnt == START_LAST) state_nxt = WAIT_RESP;
      WAIT_RESP: begin
        if (fall) state_nxt = RESP_LOW;
        else if (timeout) begin fail_now = 1'b1; fail_code = 2'b01; end
      end
      RESP_LOW: begin
        if (rise) state_nxt = RESP_HIGH;
        else if (timeout) begin fail_now = 1'b1; fail_code = 2'b01; end
      end
      RESP_HIGH: begin
        if (fall) state_nxt = BIT_LOW;
        else if (timeout) begin fail_now = 1'b1; fail_code = 2'b01; end
      end
      BIT_LOW: begin
        if (rise) state_nxt = BIT_HIGH;
        else if (timeout) begin fail_now = 1'b1; fail_code = 2'b10; end
      end
      BIT_HIGH: begin
        if (fall) state_nxt = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
        else if (timeout) begin fail_now = 1'b1; fail_code = 2'b10; end
      end
      CHECK:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (fail_now) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tick_src_q <= 1'b0;
      dht_s1     <= 1'b1;
      dht_s2     <= 1'b1;
      dht_q      <= 1'b1;
      dht_oe     <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      hum_int    <= '0;
      hum_dec    <= '0;
      tmp_int    <= '0;
      tmp_dec    <= '0;
    end else begin
      tick_src_q <= tick_src;
      dht_s1     <= dht_in;
      dht_s2     <= dht_s1;
      dht_q      <= dht_s2;
      valid      <= 1'b0;
      err        <= 1'b0;
      state      <= state_nxt;

      if (state_nxt != state) cnt <= '0;
      else if (tick && cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if (state == IDLE && start) begin
        busy     <= 1'b1;
        dht_oe   <= 1'b1;
        err_code <= 2'b00;
        bit_cnt  <= '0;
        shift    <= '0;
      end

      if (state == START_LOW && state_nxt == WAIT_RESP) dht_oe <= 1'b0;

      if (state == BIT_HIGH && fall) begin
        shift   <= {shift[38:0], (cnt > THRESH_C)};
        bit_cnt <= bit_cnt + 6'd1;
      end

      if (state == CHECK) begin
        busy <= 1'b0;
        if (sum == shift[7:0]) begin
          hum_int  <= shift[39:32];
          hum_dec  <= shift[31:24];
          tmp_int  <= shift[23:16];
          tmp_dec  <= shift[15:8];
          valid    <= 1'b1;
          err_code <= 2'b00;
        end else begin
          err      <= 1'b1;
          err_code <= 2'b11;
        end
      end

      if (fail_now) begin
        err      <= 1'b1;
        err_code <= fail_code;
        dht_oe   <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader: a behavioural DHT11 drives the line on a
// compressed time base (one tick = two clk periods).
module tb_dht11_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_src = 1'b0;
  logic       start = 1'b0;
  logic       sensor_rel = 1'b1;
  logic       dht_in;
  logic       dht_oe, busy, valid, err;
  logic [1:0] err_code;
  logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;

  int checks = 0;
  int failures = 0;

  int   valid_total = 0, err_total = 0, both_total = 0;
  int   cyc = 0, oe_fall_cyc = 0, err_cyc = 0;
  logic busy_at_valid = 1'b1;
  logic oe_q = 1'b0;

  // Open-drain line: host or sensor can pull low, pull-up otherwise.
  assign dht_in = sensor_rel & ~dht_oe;

  dht11_reader #(
    .T_START_LOW (20),
    .T_TIMEOUT   (200),
    .T_BIT_THRESH(48),
    .CNT_W       (15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_src(tick_src),
    .start   (start),
    .dht_in  (dht_in),
    .dht_oe  (dht_oe),
    .busy    (busy),
    .valid   (valid),
    .err     (err),
    .err_code(err_code),
    .hum_int (hum_int),
    .hum_dec (hum_dec),
    .tmp_int (tmp_int),
    .tmp_dec (tmp_dec)
  );

  always #10 clk = ~clk;
  always @(negedge clk) tick_src = ~tick_src;

  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      valid_total++;
      busy_at_valid = busy;
    end
    if (err) begin
      err_total++;
      err_cyc = cyc;
    end
    if (valid && err) both_total++;
    if (oe_q && !dht_oe) oe_fall_cyc = cyc;
    oe_q = dht_oe;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_oe_release();
    int k = 0;
    while (dht_oe && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk_eq("oe_release_bound", 64'(k < 2000), 1);
  endtask

  task automatic wait_event(input int v0, input int e0, input int limit);
    int k = 0;
    while (valid_total == v0 && err_total == e0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk_eq("result_bound", 64'(k < limit), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic sensor_frame(input logic [39:0] frame, input int nbits, input bit mid_start);
    wait_oe_release();
    wait_us(20);
    sensor_rel = 1'b0;
    wait_us(80);
    sensor_rel = 1'b1;
    wait_us(80);
    for (int i = 0; i < nbits; i++) begin
      sensor_rel = 1'b0;
      if (mid_start && i == 5) begin
        wait_us(10);
        pulse_start();
        chk_eq("no_restart", {dht_oe, busy}, 2'b01);
        wait_us(40);
      end else begin
        wait_us(50);
      end
      sensor_rel = 1'b1;
      wait_us(frame[39 - i] ? 70 : 27);
    end
    if (nbits == 40) begin
      sensor_rel = 1'b0;
      wait_us(50);
      sensor_rel = 1'b1;
    end
  endtask

  initial begin
    int v0, e0;

    repeat (3) @(negedge clk);
    chk_eq("rst_outs", {dht_oe, busy, valid, err, err_code}, 0);
    chk_eq("rst_bytes", {hum_int, hum_dec, tmp_int, tmp_dec}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of the host start pulse
    pulse_start();
    repeat (4) @(negedge clk);
    chk_eq("start_low_oe", {dht_oe, busy}, 2'b11);
    #3 rst = 1'b0;
    #1 chk_eq("async_rst", {dht_oe, busy, valid, err}, 0);
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("post_rst_bytes", {hum_int, hum_dec, tmp_int, tmp_dec}, 0);
    chk_eq("post_rst_idle", {dht_oe, busy}, 0);

    // Good frame
    v0 = valid_total; e0 = err_total;
    pulse_start();
    sensor_frame(40'h3700190050, 40, 1'b0);
    wait_event(v0, e0, 1000);
    chk_eq("good_valid_cnt", 64'(valid_total - v0), 1);
    chk_eq("good_err_cnt", 64'(err_total - e0), 0);
    chk_eq("good_bytes", {hum_int, hum_dec, tmp_int, tmp_dec}, 32'h37001900);
    chk_eq("good_code", err_code, 2'b00);
    chk_eq("good_busy_at_valid", busy_at_valid, 1'b0);
    chk_eq("good_idle", {dht_oe, busy}, 0);

    // Checksum failure with different payload: bytes must not move
    v0 = valid_total; e0 = err_total;
    pulse_start();
    sensor_frame(40'h4001200264, 40, 1'b0);
    wait_event(v0, e0, 1000);
    chk_eq("cks_err_cnt", 64'(err_total - e0), 1);
    chk_eq("cks_valid_cnt", 64'(valid_total - v0), 0);
    chk_eq("cks_code", err_code, 2'b11);
    chk_eq("cks_bytes_held", {hum_int, hum_dec, tmp_int, tmp_dec}, 32'h37001900);

    // No response: line stays high after release
    v0 = valid_total; e0 = err_total;
    pulse_start();
    wait_oe_release();
    wait_event(v0, e0, 1000);
    chk_eq("noresp_err_cnt", 64'(err_total - e0), 1);
    chk_eq("noresp_code", err_code, 2'b01);
    chk_eq("noresp_oe_busy", {dht_oe, busy}, 0);
    chk_eq("noresp_window",
           64'((err_cyc - oe_fall_cyc) >= 395 && (err_cyc - oe_fall_cyc) <= 410), 1);

    // Start in IDLE after err clears code; start mid-frame is ignored
    v0 = valid_total; e0 = err_total;
    pulse_start();
    chk_eq("restart_code_clear", err_code, 2'b00);
    chk_eq("restart_oe", {dht_oe, busy}, 2'b11);
    sensor_frame(40'h41051A0363, 40, 1'b1);
    wait_event(v0, e0, 1000);
    chk_eq("busy_start_valid_cnt", 64'(valid_total - v0), 1);
    chk_eq("busy_start_err_cnt", 64'(err_total - e0), 0);
    chk_eq("busy_start_bytes", {hum_int, hum_dec, tmp_int, tmp_dec}, 32'h41051A03);

    // Data timeout: sensor freezes high during bit 17
    v0 = valid_total; e0 = err_total;
    pulse_start();
    sensor_frame(40'h3700190050, 17, 1'b0);
    wait_event(v0, e0, 1000);
    chk_eq("dto_err_cnt", 64'(err_total - e0), 1);
    chk_eq("dto_valid_cnt", 64'(valid_total - v0), 0);
    chk_eq("dto_code", err_code, 2'b10);
    chk_eq("dto_bytes_held", {hum_int, hum_dec, tmp_int, tmp_dec}, 32'h41051A03);

    // Line stuck low after the response begins
    v0 = valid_total; e0 = err_total;
    pulse_start();
    wait_oe_release();
    wait_us(20);
    sensor_rel = 1'b0;
    wait_event(v0, e0, 1000);
    sensor_rel = 1'b1;
    chk_eq("stuck_low_err_cnt", 64'(err_total - e0), 1);
    chk_eq("stuck_low_code", err_code, 2'b01);

    chk_eq("valid_err_overlap", 64'(both_total), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
